// File: rtl/score_display_pkg.sv
// Shared constants for the score display: segment patterns, digit count and blink FSM states.
// Segment patterns are active-low {g,f,e,d,c,b,a}.
package score_display_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic {
    IDLE  = 1'b0,
    FLASH = 1'b1
  } flash_state_t;

endpackage

// File: rtl/bcd_to_seg.sv
// BCD digit to active-low seven-segment pattern; values above 9 show "E".
// Latency: combinational. Backpressure: none.
// Flow control: pure function of the input, no handshake.
module bcd_to_seg
  import score_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule

// File: rtl/score_display_scan.sv
// Scans a latched two-digit BCD score onto a 4-digit common-anode display and blinks on score change.
// Latency: pins lag the internal index/latch by 1 cycle. Backpressure: none, score inputs are level-sampled.
module score_display_scan
  import score_display_pkg::*;
#(
  parameter int SCAN_CYCLES   = 100000,
  parameter int FLASH_FRAMES  = 64,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       dis_score,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int SCAN_W  = $clog2(SCAN_CYCLES);
  localparam int FRAME_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam int TOG_W   = $clog2(FLASH_TOGGLES);
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(FLASH_FRAMES - 1);
  localparam logic [TOG_W-1:0]   TOG_LAST   = TOG_W'(FLASH_TOGGLES - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [SCAN_W-1:0]  scan_cnt;
  logic [IDX_W-1:0]   idx;
  logic [7:0]         latch;
  flash_state_t       state, state_n;
  logic [FRAME_W-1:0] frame_cnt, frame_n;
  logic [TOG_W-1:0]   tog_cnt, tog_n;

  logic       scan_wrap;
  logic       frame_bnd;
  logic       changed;
  logic       blank;
  logic [3:0] digit;
  logic       digit_on;
  logic [6:0] digit_seg;

  assign scan_wrap = (scan_cnt == SCAN_LAST);
  assign frame_bnd = scan_wrap && (idx == IDX_LAST);
  assign changed   = frame_bnd && ({score1, score0} != latch);
  assign blank     = !dis_score || ((state == FLASH) && tog_cnt[0]);
  assign dp        = 1'b1;

  // The scan keeps running while disabled so re-enable resumes on the same cadence.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
      idx      <= idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // Only frame-boundary samples reach the latch, so a digit never tears mid-frame.
  always_ff @(posedge clk) begin
    if (rst || !dis_score) begin
      latch <= '0;
    end else if (frame_bnd) begin
      latch <= {score1, score0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      frame_cnt <= '0;
      tog_cnt   <= '0;
    end else begin
      state     <= state_n;
      frame_cnt <= frame_n;
      tog_cnt   <= tog_n;
    end
  end

  always_comb begin
    state_n = state;
    frame_n = frame_cnt;
    tog_n   = tog_cnt;
    if (!dis_score) begin
      state_n = IDLE;
      frame_n = '0;
      tog_n   = '0;
    end else if (changed) begin
      state_n = FLASH;
      frame_n = '0;
      tog_n   = '0;
    end else if ((state == FLASH) && frame_bnd) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_n = '0;
        if (tog_cnt == TOG_LAST) begin
          state_n = IDLE;
          tog_n   = '0;
        end else begin
          tog_n = tog_cnt + 1'b1;
        end
      end else begin
        frame_n = frame_cnt + 1'b1;
      end
    end
  end

  // Tens digit is blanked when zero; the two upper positions never show anything.
  always_comb begin
    digit    = latch[3:0];
    digit_on = 1'b0;
    case (idx)
      IDX_W'(0): begin
        digit    = latch[3:0];
        digit_on = 1'b1;
      end
      IDX_W'(1): begin
        digit    = latch[7:4];
        digit_on = (latch[7:4] != 4'd0);
      end
      default: begin
        digit    = latch[3:0];
        digit_on = 1'b0;
      end
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit),
    .seg (digit_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << idx);
      seg <= digit_on ? digit_seg : SEG_BLANK;
    end
  end

endmodule

// File: tb/tb_score_display_scan.sv
// Randomized and directed bench for score_display_scan against a cycle-count based reference model.
module tb_score_display_scan;

  localparam int SC    = 4;
  localparam int FF    = 2;
  localparam int FT    = 4;
  localparam int FRAME = SC * 4;
  localparam int BLINK = FRAME * FF * FT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dis_score = 1'b0;
  logic [3:0] score0 = 4'd0;
  logic [3:0] score1 = 4'd0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int n_cmp = 0;
  int n_bad = 0;

  score_display_scan #(
    .SCAN_CYCLES   (SC),
    .FLASH_FRAMES  (FF),
    .FLASH_TOGGLES (FT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dis_score (dis_score),
    .score0    (score0),
    .score1    (score1),
    .seg       (seg),
    .an        (an),
    .dp        (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0000110, 7'b0000110,
    7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110
  };

  // Reference: m_n counts clock edges since reset; position, frame and blink phase follow by division.
  int unsigned m_n     = 0;
  int unsigned m_start = 0;
  int unsigned m_dig   = 0;
  logic [7:0]  m_latch = 8'd0;
  bit          m_flash = 1'b0;
  bit          m_active;
  bit          m_blank;
  logic [3:0]  exp_an  = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;

  always @(posedge clk) begin
    if (rst) begin
      m_n = 0; m_latch = 8'd0; m_flash = 1'b0; m_start = 0;
      exp_an = 4'hF; exp_seg = 7'h7F;
    end else begin
      m_dig    = (m_n / SC) % 4;
      m_active = m_flash && ((m_n - m_start) <= BLINK);
      m_blank  = !dis_score || (m_active && ((((m_n - m_start - 1) / FRAME) / FF) % 2 == 1));
      if (m_blank) begin
        exp_an = 4'hF; exp_seg = 7'h7F;
      end else begin
        exp_an = ~(4'b0001 << m_dig);
        case (m_dig)
          0: exp_seg = seg_tab[m_latch[3:0]];
          1: exp_seg = (m_latch[7:4] == 4'd0) ? 7'h7F : seg_tab[m_latch[7:4]];
          default: exp_seg = 7'h7F;
        endcase
      end
      if (!dis_score) begin
        m_latch = 8'd0; m_flash = 1'b0;
      end else if (m_n % FRAME == FRAME - 1) begin
        if ({score1, score0} != m_latch) begin
          m_flash = 1'b1; m_start = m_n;
        end
        m_latch = {score1, score0};
      end
      m_n++;
    end
  end

  task automatic test_reset();
    logic [3:0] want_an;
    @(negedge clk);
    rst = 1'b1; dis_score = 1'b1; score0 = 4'd0; score1 = 4'd0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_vals: an=%b seg=%b dp=%b expected an=1111 seg=1111111 dp=1", an, seg, dp);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      want_an = ~(4'b0001 << (k / 4));
      n_cmp++;
      if (an !== want_an || an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL reset_scan k=%0d: an=%b seg=%b expected an=%b seg=%b", k, an, seg, want_an, exp_seg);
      end
    end
  endtask

  task automatic test_static(input logic [3:0] s1, input logic [3:0] s0,
                             input logic [6:0] want0, input logic [6:0] want1);
    score1 = s1; score0 = s0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL static_model %0d%0d: an=%b seg=%b expected an=%b seg=%b", s1, s0, an, seg, exp_an, exp_seg);
      end
      if (k >= 20 && an === 4'b1110) begin
        n_cmp++;
        if (seg !== want0) begin
          n_bad++;
          $display("FAIL static_ones %0d%0d: seg=%b expected %b", s1, s0, seg, want0);
        end
      end
      if (k >= 20 && an === 4'b1101) begin
        n_cmp++;
        if (seg !== want1) begin
          n_bad++;
          $display("FAIL static_tens %0d%0d: seg=%b expected %b", s1, s0, seg, want1);
        end
      end
    end
  endtask

  task automatic test_no_tear();
    int guard;
    score1 = 4'd0; score0 = 4'd3;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL tear_model: an=%b seg=%b expected an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end while ((guard < 40 || m_n % FRAME != 6) && guard < 100);
    score0 = 4'd4;
    for (int j = 0; j < 26; j++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL tear_model j=%0d: an=%b seg=%b expected an=%b seg=%b", j, an, seg, exp_an, exp_seg);
      end
      if (an === 4'b1110) begin
        n_cmp++;
        if (seg !== ((j < 10) ? 7'b0110000 : 7'b0011001)) begin
          n_bad++;
          $display("FAIL tear_digit j=%0d: seg=%b", j, seg);
        end
      end
    end
  endtask

  task automatic test_flash();
    int guard;
    int blanks;
    score1 = 4'd0; score0 = 4'd4;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL flash_model: an=%b seg=%b expected an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
    end while ((guard < BLINK + 32 || m_n % FRAME != 8) && guard < BLINK + 64);
    score0 = 4'd1;
    blanks = 0;
    for (int j = 0; j < 240; j++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL flash_model j=%0d: an=%b seg=%b expected an=%b seg=%b", j, an, seg, exp_an, exp_seg);
      end
      if (an === 4'hF) blanks++;
      if (j == 39) score0 = 4'd2;
    end
    n_cmp++;
    if (blanks != 16 + 2 * 2 * FRAME) begin
      n_bad++;
      $display("FAIL flash_restart: blank cycles=%0d expected %0d", blanks, 16 + 2 * 2 * FRAME);
    end
  endtask

  task automatic test_invalid();
    score1 = 4'd0; score0 = 4'hC;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL invalid_model: an=%b seg=%b expected an=%b seg=%b", an, seg, exp_an, exp_seg);
      end
      if (k >= 20 && an === 4'b1110) begin
        n_cmp++;
        if (seg !== 7'b0000110) begin
          n_bad++;
          $display("FAIL invalid_E: seg=%b expected 0000110", seg);
        end
      end
    end
  endtask

  task automatic test_disable();
    int blanks;
    score1 = 4'd0; score0 = 4'd5;
    repeat (40) @(negedge clk);
    dis_score = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== 4'hF || seg !== 7'h7F || an !== exp_an) begin
        n_bad++;
        $display("FAIL disable_blank k=%0d: an=%b seg=%b expected an=1111 seg=1111111", k, an, seg);
      end
    end
    dis_score = 1'b1; score0 = 4'd0;
    for (int k = 0; k < 160; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an === 4'hF || an !== exp_an || seg !== exp_seg) begin
        n_bad++;
        $display("FAIL reenable_noblink k=%0d: an=%b seg=%b expected an=%b seg=%b", k, an, seg, exp_an, exp_seg);
      end
    end
    score0 = 4'd1;
    blanks = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (an === 4'hF) blanks++;
    end
    n_cmp++;
    if (blanks != 2 * FF * FRAME) begin
      n_bad++;
      $display("FAIL reenable_blink: blank cycles=%0d expected %0d", blanks, 2 * FF * FRAME);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      n_cmp++;
      if (an !== exp_an || seg !== exp_seg || dp !== 1'b1) begin
        n_bad++;
        $display("FAIL random k=%0d: an=%b seg=%b dp=%b expected an=%b seg=%b", k, an, seg, dp, exp_an, exp_seg);
      end
      rst = 1'b0;
      if ($urandom_range(0, 11) == 0) begin
        score0 = 4'($urandom_range(0, 15));
        score1 = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 59) == 0) dis_score = ~dis_score;
      if ($urandom_range(0, 299) == 0) rst = 1'b1;
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_static(4'd0, 4'd7, 7'b1111000, 7'b1111111);
    test_static(4'd2, 4'd5, 7'b0010010, 7'b0100100);
    test_no_tear();
    test_flash();
    test_invalid();
    test_disable();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
